// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the memory port arbiter.
// Owner tags, FSM states and the owner FIFO entry layout.
package mem_port_arbiter_pkg;

   localparam logic OWNER_INST = 1'b0;
   localparam logic OWNER_DATA = 1'b1;

   localparam logic [0:0] ARB_IDLE = 1'b0;
   localparam logic [0:0] ARB_HOLD = 1'b1;

   localparam int FIFO_ENTRY_W = 2;

   typedef struct packed {
      logic owner;
      logic cancel;
   } owner_ent_t;

endpackage

// File: rtl/mem_port_arbiter_owner_fifo.sv
// Owner FIFO: one entry per accepted, unanswered transaction.
// Each entry records its requester and whether a flush voided it.
module arb_owner_fifo
   import mem_port_arbiter_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       push_i,
   input  logic       push_owner_i,
   input  logic       pop_i,
   input  logic       cancel_inst_i,
   output logic       full_o,
   output logic       empty_o,
   output owner_ent_t head_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

   owner_ent_t    ent_q [DEPTH];
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [AW:0]   cnt_q;
   logic [AW:0]   cnt_d;

   // Bulk-cancel fetch entries, then write the new tail entry.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            ent_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (cancel_inst_i && ent_q[i].owner == OWNER_INST) begin
               ent_q[i].cancel <= 1'b1;
            end
         end
         if (push_i) begin
            ent_q[wr_ptr_q].owner  <= push_owner_i;
            ent_q[wr_ptr_q].cancel <= cancel_inst_i &&
                                      (push_owner_i == OWNER_INST);
         end
      end
   end

   // Occupancy: a push and a pop in one cycle leave it unchanged.
   always_comb begin
      cnt_d = cnt_q;
      if (push_i && !pop_i) begin
         cnt_d = cnt_q + (AW+1)'(1);
      end else if (!push_i && pop_i) begin
         cnt_d = cnt_q - (AW+1)'(1);
      end
   end

   // Circular pointers and count.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
         cnt_q <= cnt_d;
      end
   end

   assign full_o  = (cnt_q == CNT_FULL);
   assign empty_o = (cnt_q == '0);
   assign head_o  = ent_q[rd_ptr_q];

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the shared memory port between fetch and data sides.
// Responses return in order and are routed by the owner FIFO.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int MAX_OUTST       = 4,
   parameter int DATA_STREAK_MAX = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        flush,
   input  logic        inst_req,
   input  logic [31:0] inst_addr,
   output logic        inst_addr_ok,
   output logic        inst_data_ok,
   output logic [31:0] inst_rdata,
   input  logic        data_req,
   input  logic        data_wr,
   input  logic [3:0]  data_wstrb,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   output logic        data_addr_ok,
   output logic        data_data_ok,
   output logic [31:0] data_rdata,
   output logic        mem_req,
   output logic        mem_wr,
   output logic [3:0]  mem_wstrb,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_addr_ok,
   input  logic        mem_data_ok,
   input  logic [31:0] mem_rdata
);

   localparam int SW = $clog2(DATA_STREAK_MAX + 1);
   localparam logic [SW-1:0] STREAK_MAX = SW'(DATA_STREAK_MAX);

   logic [0:0]    state_q;
   logic [0:0]    state_d;
   logic          owner_q;
   logic          owner_d;
   logic [SW-1:0] streak_q;
   logic [SW-1:0] streak_d;

   logic       win_own;
   logic       grant_v;
   logic       grant_own;
   logic       accept;
   logic       pop;
   logic       fifo_full;
   logic       fifo_empty;
   owner_ent_t fifo_head;

   // Pick a winner in IDLE; keep the latched owner while holding.
   always_comb begin
      win_own = OWNER_INST;
      if (data_req && !(inst_req && streak_q == STREAK_MAX)) begin
         win_own = OWNER_DATA;
      end
      grant_v   = 1'b0;
      grant_own = win_own;
      state_d   = state_q;
      owner_d   = owner_q;
      if (state_q == ARB_HOLD) begin
         grant_v   = 1'b1;
         grant_own = owner_q;
         if (mem_addr_ok) state_d = ARB_IDLE;
      end else begin
         grant_v = (inst_req || data_req) && !fifo_full;
         if (grant_v && !mem_addr_ok) begin
            state_d = ARB_HOLD;
            owner_d = win_own;
         end
      end
      if (reset) grant_v = 1'b0;
   end

   assign accept       = grant_v && mem_addr_ok;
   assign inst_addr_ok = accept && (grant_own == OWNER_INST);
   assign data_addr_ok = accept && (grant_own == OWNER_DATA);

   // Drive the shared port from the granted requester.
   always_comb begin
      mem_req   = grant_v;
      mem_wr    = 1'b0;
      mem_wstrb = '0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (grant_v) begin
         if (grant_own == OWNER_DATA) begin
            mem_wr    = data_wr;
            mem_wstrb = data_wr ? data_wstrb : 4'h0;
            mem_addr  = data_addr;
            mem_wdata = data_wdata;
         end else begin
            mem_addr  = inst_addr;
         end
      end
   end

   // Count data wins while a fetch waits; any fetch win resets it.
   always_comb begin
      streak_d = streak_q;
      if (accept && grant_own == OWNER_DATA && inst_req) begin
         if (streak_q != STREAK_MAX) streak_d = streak_q + SW'(1);
      end else if ((accept && grant_own == OWNER_INST) || !inst_req) begin
         streak_d = '0;
      end
   end

   // FSM, held owner and streak registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ARB_IDLE;
         owner_q  <= OWNER_INST;
         streak_q <= '0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         streak_q <= streak_d;
      end
   end

   assign pop = mem_data_ok && !fifo_empty && !reset;

   arb_owner_fifo #(
      .DEPTH(MAX_OUTST)
   ) u_fifo (
      .clk          (clk),
      .reset        (reset),
      .push_i       (accept),
      .push_owner_i (grant_own),
      .pop_i        (pop),
      .cancel_inst_i(flush),
      .full_o       (fifo_full),
      .empty_o      (fifo_empty),
      .head_o       (fifo_head)
   );

   assign data_data_ok = pop && (fifo_head.owner == OWNER_DATA);
   assign inst_data_ok = pop && (fifo_head.owner == OWNER_INST) &&
                         !fifo_head.cancel;
   assign data_rdata   = data_data_ok ? mem_rdata : 32'h0;
   assign inst_rdata   = inst_data_ok ? mem_rdata : 32'h0;

   // A response with nothing outstanding is a bridge protocol error.
   a_no_orphan_rsp: assert property (
      @(posedge clk) disable iff (reset) !(mem_data_ok && fifo_empty)
   );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter.
// Expected responses are queued at issue and matched on return.
module tb_mem_port_arbiter;

   localparam int K_INST = 0;
   localparam int K_DATA = 1;
   localparam int K_NONE = 2;

   typedef struct {
      int          kind;
      logic [31:0] rdata;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        flush = 1'b0;
   logic        inst_req = 1'b0;
   logic [31:0] inst_addr = '0;
   logic        inst_addr_ok;
   logic        inst_data_ok;
   logic [31:0] inst_rdata;
   logic        data_req = 1'b0;
   logic        data_wr = 1'b0;
   logic [3:0]  data_wstrb = '0;
   logic [31:0] data_addr = '0;
   logic [31:0] data_wdata = '0;
   logic        data_addr_ok;
   logic        data_data_ok;
   logic [31:0] data_rdata;
   logic        mem_req;
   logic        mem_wr;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_addr_ok = 1'b0;
   logic        mem_data_ok = 1'b0;
   logic [31:0] mem_rdata = '0;

   int   checks = 0;
   int   fails = 0;
   exp_t exp_q[$];
   exp_t mon_e;

   always #5 clk = ~clk;

   mem_port_arbiter dut (
      .clk         (clk),
      .reset       (reset),
      .flush       (flush),
      .inst_req    (inst_req),
      .inst_addr   (inst_addr),
      .inst_addr_ok(inst_addr_ok),
      .inst_data_ok(inst_data_ok),
      .inst_rdata  (inst_rdata),
      .data_req    (data_req),
      .data_wr     (data_wr),
      .data_wstrb  (data_wstrb),
      .data_addr   (data_addr),
      .data_wdata  (data_wdata),
      .data_addr_ok(data_addr_ok),
      .data_data_ok(data_data_ok),
      .data_rdata  (data_rdata),
      .mem_req     (mem_req),
      .mem_wr      (mem_wr),
      .mem_wstrb   (mem_wstrb),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_addr_ok (mem_addr_ok),
      .mem_data_ok (mem_data_ok),
      .mem_rdata   (mem_rdata)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_rsp(input int kind, input logic [31:0] rd);
      exp_t e;
      e.kind  = kind;
      e.rdata = rd;
      exp_q.push_back(e);
   endtask

   task automatic idle();
      inst_req    = 1'b0;
      data_req    = 1'b0;
      data_wr     = 1'b0;
      data_wstrb  = 4'h0;
      mem_addr_ok = 1'b0;
      mem_data_ok = 1'b0;
      mem_rdata   = '0;
      flush       = 1'b0;
   endtask

   function automatic logic [31:0] ctrl_bits();
      return 32'({mem_req, mem_wr, mem_wstrb, inst_addr_ok,
                  inst_data_ok, data_addr_ok, data_data_ok});
   endfunction

   function automatic logic [31:0] bus_bits();
      return mem_addr | mem_wdata | inst_rdata | data_rdata;
   endfunction

   // Scoreboard: every response cycle pops one expectation.
   always @(negedge clk) begin
      if (!reset) begin
         if (mem_data_ok) begin
            chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
               mon_e = exp_q.pop_front();
               chk("rsp_inst_ok", 32'(inst_data_ok),
                   32'(mon_e.kind == K_INST));
               chk("rsp_data_ok", 32'(data_data_ok),
                   32'(mon_e.kind == K_DATA));
               chk("rsp_inst_rd", inst_rdata,
                   (mon_e.kind == K_INST) ? mon_e.rdata : 32'h0);
               chk("rsp_data_rd", data_rdata,
                   (mon_e.kind == K_DATA) ? mon_e.rdata : 32'h0);
            end
         end else begin
            chk("no_rsp_ok", 32'({inst_data_ok, data_data_ok}), 32'd0);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

   initial begin
      string pat;
      logic  isd;
      pat = "DDDIDDDI";

      // reset: outputs forced low even with requests pending
      cyc();
      inst_req = 1'b1;
      data_req = 1'b1;
      inst_addr = 32'h1234;
      data_addr = 32'h5678;
      #1;
      chk("rst_ctrl", ctrl_bits(), 32'd0);
      chk("rst_bus", bus_bits(), 32'd0);
      cyc();
      reset = 1'b0;
      idle();

      // single fetch
      cyc();
      inst_req    = 1'b1;
      inst_addr   = 32'hBFC0_0000;
      mem_addr_ok = 1'b1;
      #1;
      chk("t1_req", 32'(mem_req), 32'd1);
      chk("t1_addr", mem_addr, 32'hBFC0_0000);
      chk("t1_iaok", 32'(inst_addr_ok), 32'd1);
      chk("t1_daok", 32'(data_addr_ok), 32'd0);
      expect_rsp(K_INST, 32'h3C08_0001);
      cyc();
      idle();
      #1;
      chk("t1_iaok_drop", 32'(inst_addr_ok), 32'd0);
      cyc();
      mem_data_ok = 1'b1;
      mem_rdata   = 32'h3C08_0001;
      cyc();
      idle();

      // contended grants with a streak limit of three
      inst_addr = 32'h100;
      data_addr = 32'h200;
      for (int k = 0; k < 9; k++) begin
         cyc();
         inst_req    = (k < 8);
         data_req    = (k < 8);
         mem_addr_ok = (k < 8);
         mem_data_ok = (k > 0);
         mem_rdata   = 32'h1000 + 32'(k - 1);
         #1;
         if (k < 8) begin
            isd = (pat[k] == "D");
            chk("t2_dgrant", 32'(data_addr_ok), 32'(isd));
            chk("t2_igrant", 32'(inst_addr_ok), 32'(!isd));
            chk("t2_addr", mem_addr, isd ? 32'h200 : 32'h100);
            expect_rsp(isd ? K_DATA : K_INST, 32'h1000 + 32'(k));
         end
      end
      cyc();
      idle();

      // store held for four cycles while a fetch arrives
      for (int k = 0; k < 4; k++) begin
         cyc();
         data_req    = 1'b1;
         data_wr     = 1'b1;
         data_wstrb  = 4'hF;
         data_addr   = 32'h8000_0010;
         data_wdata  = 32'hDEAD_BEEF;
         inst_req    = (k > 0);
         inst_addr   = 32'hBFC0_0004;
         mem_addr_ok = (k == 3);
         #1;
         chk("t3_req", 32'(mem_req), 32'd1);
         chk("t3_wr", 32'(mem_wr), 32'd1);
         chk("t3_addr", mem_addr, 32'h8000_0010);
         chk("t3_wstrb", 32'(mem_wstrb), 32'hF);
         chk("t3_wdata", mem_wdata, 32'hDEAD_BEEF);
         chk("t3_daok", 32'(data_addr_ok), 32'(k == 3));
         chk("t3_iaok", 32'(inst_addr_ok), 32'd0);
      end
      expect_rsp(K_DATA, 32'h0);
      cyc();
      data_req    = 1'b0;
      data_wr     = 1'b0;
      inst_req    = 1'b1;
      mem_addr_ok = 1'b1;
      #1;
      chk("t3_iaok2", 32'(inst_addr_ok), 32'd1);
      chk("t3_addr2", mem_addr, 32'hBFC0_0004);
      chk("t3_wstrb2", 32'(mem_wstrb), 32'h0);
      expect_rsp(K_INST, 32'h1111_1111);
      cyc();
      idle();
      mem_data_ok = 1'b1;
      mem_rdata   = 32'h0;
      cyc();
      mem_data_ok = 1'b1;
      mem_rdata   = 32'h1111_1111;
      cyc();
      idle();

      // fill the FIFO, then push and pop together
      for (int k = 0; k < 4; k++) begin
         cyc();
         inst_req    = 1'b1;
         inst_addr   = 32'h100 + 32'(4 * k);
         mem_addr_ok = 1'b1;
         #1;
         chk("t4_fill", 32'(inst_addr_ok), 32'd1);
         expect_rsp(K_INST, 32'h2000 + 32'(k));
      end
      cyc();
      inst_addr   = 32'h110;
      mem_addr_ok = 1'b0;
      #1;
      chk("t4_full", 32'(mem_req), 32'd0);
      cyc();
      mem_data_ok = 1'b1;
      mem_rdata   = 32'h2000;
      #1;
      chk("t4_full_pop", 32'(mem_req), 32'd0);
      cyc();
      mem_addr_ok = 1'b1;
      mem_data_ok = 1'b1;
      mem_rdata   = 32'h2001;
      #1;
      chk("t4_pushpop", 32'(inst_addr_ok), 32'd1);
      expect_rsp(K_INST, 32'h2004);
      cyc();
      inst_addr   = 32'h114;
      mem_data_ok = 1'b0;
      #1;
      chk("t4_refill", 32'(inst_addr_ok), 32'd1);
      expect_rsp(K_INST, 32'h2005);
      cyc();
      inst_addr = 32'h118;
      #1;
      chk("t4_full2", 32'(mem_req), 32'd0);
      cyc();
      idle();
      for (int k = 2; k < 6; k++) begin
         mem_data_ok = 1'b1;
         mem_rdata   = 32'h2000 + 32'(k);
         cyc();
      end
      idle();

      // flush cancels both fetches, store still completes
      cyc();
      inst_req    = 1'b1;
      inst_addr   = 32'h300;
      mem_addr_ok = 1'b1;
      expect_rsp(K_NONE, 32'h0);
      cyc();
      inst_req    = 1'b0;
      data_req    = 1'b1;
      data_wr     = 1'b1;
      data_wstrb  = 4'h3;
      data_addr   = 32'h8000_0020;
      #1;
      chk("t5_store", 32'(data_addr_ok), 32'd1);
      expect_rsp(K_DATA, 32'hBBBB);
      cyc();
      data_req  = 1'b0;
      data_wr   = 1'b0;
      inst_req  = 1'b1;
      inst_addr = 32'h304;
      flush     = 1'b1;
      #1;
      chk("t5_fetch_c", 32'(inst_addr_ok), 32'd1);
      expect_rsp(K_NONE, 32'h0);
      cyc();
      idle();
      mem_data_ok = 1'b1;
      mem_rdata   = 32'hAAAA;
      cyc();
      mem_rdata = 32'hBBBB;
      cyc();
      mem_rdata = 32'hCCCC;
      cyc();
      idle();

      // reset with two outstanding and a held request
      cyc();
      inst_req    = 1'b1;
      inst_addr   = 32'h400;
      mem_addr_ok = 1'b1;
      cyc();
      inst_req = 1'b0;
      data_req = 1'b1;
      cyc();
      data_req    = 1'b0;
      inst_req    = 1'b1;
      inst_addr   = 32'h404;
      mem_addr_ok = 1'b0;
      #1;
      chk("t6_hold_req", 32'(mem_req), 32'd1);
      cyc();
      reset = 1'b1;
      idle();
      #1;
      chk("t6_rst_ctrl", ctrl_bits(), 32'd0);
      cyc();
      reset = 1'b0;
      #1;
      chk("t6_post_ctrl", ctrl_bits(), 32'd0);
      chk("t6_post_bus", bus_bits(), 32'd0);
      for (int k = 0; k < 4; k++) begin
         cyc();
         inst_req    = 1'b1;
         inst_addr   = 32'h500 + 32'(4 * k);
         mem_addr_ok = 1'b1;
         #1;
         chk("t6_empty_fill", 32'(inst_addr_ok), 32'd1);
         expect_rsp(K_INST, 32'h3000 + 32'(k));
      end
      cyc();
      mem_addr_ok = 1'b0;
      #1;
      chk("t6_full", 32'(mem_req), 32'd0);
      cyc();
      idle();
      for (int k = 0; k < 4; k++) begin
         mem_data_ok = 1'b1;
         mem_rdata   = 32'h3000 + 32'(k);
         cyc();
      end
      idle();
      cyc();
      chk("sb_drained", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
